decrypt_ctrl: RTL and testbench
===============================

DECRYPT_CTRL -- requirements
Module: decrypt_ctrl

Interface
REQ-001 SHALL have parameter CRYPTO_BASE, default 64, meaning the data-memory address of encrypted byte 0.
REQ-002 SHALL have parameter PLAIN_BASE, default 0, meaning the data-memory address of decrypted byte 0.
REQ-003 SHALL have parameter MSG_LEN, default 64, meaning the number of bytes decrypted per run.
REQ-004 SHALL have parameter PRE_CHK, default 10, meaning the number of leading bytes guaranteed to be plaintext space (0x00 after the 0x20 offset).
REQ-005 SHALL have port Clk, input, 1 bit, the single system clock (all logic on its rising edge).
REQ-006 SHALL have port Reset, input, 1 bit, the synchronous, active-high reset.
REQ-007 SHALL have port Start, input, 1 bit; high holds the block idle, low requests a run.
REQ-008 SHALL have port Ack, output, 1 bit, meaning the run is complete.
REQ-009 SHALL have port mem_addr, output, 8 bits, the data-memory address.
REQ-010 SHALL have port mem_we, output, 1 bit, the data-memory write enable.
REQ-011 SHALL have port mem_wdata, output, 8 bits, the data-memory write data.
REQ-012 SHALL have port mem_rdata, input, 8 bits, the data-memory read data, valid one cycle after mem_addr.
REQ-013 SHALL have port ptrn_idx, output, 4 bits, the index (0-8) of the detected LFSR tap pattern.
REQ-014 SHALL have port ptrn_err, output, 1 bit, asserted when no tap pattern is found.
REQ-015 SHALL have port par_err_cnt, output, 7 bits, the count of bytes whose parity is wrong.

Function
REQ-016 SHALL implement the states IDLE, LOAD, SEARCH, DECRYPT and DONE.
REQ-017 SHALL move from IDLE to LOAD on the first cycle with Start==0, and SHALL clear ptrn_idx, ptrn_err and par_err_cnt on that transition.
REQ-018 In LOAD, SHALL read addresses CRYPTO_BASE..CRYPTO_BASE+PRE_CHK-1 on consecutive cycles and capture each byte's [6:0] into buf[0..PRE_CHK-1]; LOAD lasts exactly PRE_CHK+1 cycles.
REQ-019 SHALL go from LOAD directly to DONE with ptrn_err=1 if buf[0]==0.
REQ-020 In SEARCH, SHALL test patterns 0..8 in order, one step per cycle: the LFSR is loaded with buf[0], step k computes next = {lfsr[5:0], ^(lfsr & PTRN[p])} and compares it with buf[k], for k = 1..PRE_CHK-1.
REQ-021 On a mismatch, SHALL advance to the next pattern on the next cycle and reload the LFSR from buf[0].
REQ-022 The first pattern whose PRE_CHK-1 comparisons all match SHALL be latched into ptrn_idx, and the block SHALL enter DECRYPT with the LFSR reloaded to buf[0].
REQ-023 If all 9 patterns fail, SHALL set ptrn_err=1 and enter DONE; SEARCH lasts at most 9*(PRE_CHK-1) cycles.
REQ-024 In DECRYPT, SHALL handle each byte n = 0..MSG_LEN-1 in two cycles: a read cycle (mem_addr = CRYPTO_BASE+n, mem_we=0), then a write cycle.
REQ-025 In the write cycle, SHALL drive mem_addr = PLAIN_BASE+n, mem_we=1 and mem_wdata = ({1'b0, rdata[6:0] ^ lfsr}) + 8'h20, then step the LFSR.
REQ-026 In the write cycle, if rdata[7] != ^rdata[6:0], SHALL increment par_err_cnt (saturating at 127) and still write the decrypted byte.
REQ-027 DECRYPT SHALL last exactly 2*MSG_LEN cycles and then enter DONE.
REQ-028 mem_we SHALL be 1 only in DECRYPT write cycles; addresses SHALL not wrap (8-bit sum, parameters kept within 0..255).
REQ-029 In DONE, SHALL hold Ack=1 and keep all results stable; Start==1 SHALL return the block to IDLE with Ack=0 on the next cycle.
REQ-030 SHALL ignore Start in every state other than IDLE and DONE.

Reset
REQ-031 When Reset==1 at a clock edge, in any state including mid-DECRYPT, SHALL set state=IDLE, Ack=0, mem_we=0, mem_addr=0, mem_wdata=0, ptrn_idx=0, ptrn_err=0, par_err_cnt=0, LFSR=0 and buf=0.
REQ-032 Reset SHALL take priority over Start.

Structure
REQ-033 Package decrypt_pkg SHALL hold the state enum, the 9-entry PTRN table (0x60, 0x48, 0x78, 0x72, 0x6A, 0x69, 0x5C, 0x7E, 0x7B) and the default address constants.
REQ-034 Sub-module lfsr7 SHALL hold the 7-bit LFSR register with load/step controls and a tap input.

Verification
REQ-035 Pattern 0x72, init 0x01, pre_length 10, message "Mr. Watson, come here. I want to see you." -> mem[0..63] equal the padded message, ptrn_idx=3, ptrn_err=0, par_err_cnt=0, Ack=1 after at most 11+81+128+1 cycles.
REQ-036 Pattern 0x60, init 0x7F, all-space message -> mem[0..63] all 0x20, ptrn_idx=0.
REQ-037 Same as REQ-035 but with mem[70] bit7 flipped -> par_err_cnt=1 and mem[0..63] unchanged.
REQ-038 crypto[64] = 0x00 -> ptrn_err=1, Ack=1, no writes to mem[0..63].
REQ-039 Reset pulsed for one cycle at DECRYPT byte 20 -> Ack=0, no further writes, idle until Start is low again; the rerun is correct.
REQ-040 Start held at 1 for 200 cycles after Reset -> mem_we never 1 and Ack stays 0.

Source files
------------

// File: rtl/decrypt_pkg.sv
// Shared definitions for the decrypt controller.
//   state_e        : controller FSM states
//   ptrn_taps()    : 9-entry LFSR tap-pattern table, indexed 0..8
//   *Dflt          : default memory map and message geometry
package decrypt_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StSearch,
      StDecrypt,
      StDone
   } state_e;

   localparam int unsigned NumPtrn        = 9;
   localparam int unsigned CryptoBaseDflt = 64;
   localparam int unsigned PlainBaseDflt  = 0;
   localparam int unsigned MsgLenDflt     = 64;
   localparam int unsigned PreChkDflt     = 10;

   // Indices beyond the table return no taps; the search never reaches them.
   function automatic logic [6:0] ptrn_taps(input logic [3:0] idx);
      case (idx)
         4'd0:    return 7'h60;
         4'd1:    return 7'h48;
         4'd2:    return 7'h78;
         4'd3:    return 7'h72;
         4'd4:    return 7'h6A;
         4'd5:    return 7'h69;
         4'd6:    return 7'h5C;
         4'd7:    return 7'h7E;
         4'd8:    return 7'h7B;
         default: return 7'h00;
      endcase
   endfunction

endpackage

// File: rtl/lfsr7.sv
// 7-bit Fibonacci-style LFSR: shifts left, feedback is the XOR of the taps.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   load_i         : load load_val_i (has priority over step_i)
//   step_i         : advance one step using taps_i
//   q_o            : current register value
//   next_o         : value the register takes on a step with taps_i
module lfsr7 (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       load_i,
   input  logic [6:0] load_val_i,
   input  logic       step_i,
   input  logic [6:0] taps_i,
   output logic [6:0] q_o,
   output logic [6:0] next_o
);

   logic [6:0] q_q, q_d;

   assign next_o = {q_q[5:0], ^(q_q & taps_i)};
   assign q_o    = q_q;

   always_comb begin
      q_d = q_q;
      if (load_i) begin
         q_d = load_val_i;
      end else if (step_i) begin
         q_d = next_o;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

endmodule

// File: rtl/decrypt_ctrl.sv
// Decrypt controller: reads a 7-bit-LFSR-encrypted message from data memory,
// identifies the tap pattern from a known run of leading spaces, then writes
// the decrypted message back while counting parity errors.
//   Clk, Reset     : clock, synchronous active-high reset
//   Start          : high holds idle, low requests a run
//   Ack            : run complete (held in DONE until Start returns high)
//   mem_addr/mem_we/mem_wdata/mem_rdata : data-memory port, 1-cycle read latency
//   ptrn_idx       : detected tap pattern (0..8)
//   ptrn_err       : no tap pattern found (or first byte is zero)
//   par_err_cnt    : saturating count of bytes with bad parity
// PRE_CHK is assumed to be at least 2.
module decrypt_ctrl
   import decrypt_pkg::*;
#(
   parameter int unsigned CRYPTO_BASE = CryptoBaseDflt,
   parameter int unsigned PLAIN_BASE  = PlainBaseDflt,
   parameter int unsigned MSG_LEN     = MsgLenDflt,
   parameter int unsigned PRE_CHK     = PreChkDflt
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Start,
   output logic       Ack,
   output logic [7:0] mem_addr,
   output logic       mem_we,
   output logic [7:0] mem_wdata,
   input  logic [7:0] mem_rdata,
   output logic [3:0] ptrn_idx,
   output logic       ptrn_err,
   output logic [6:0] par_err_cnt
);

   localparam logic [7:0] CryptoBase = 8'(CRYPTO_BASE);
   localparam logic [7:0] PlainBase  = 8'(PLAIN_BASE);
   localparam logic [7:0] LoadLast   = 8'(PRE_CHK);
   localparam logic [7:0] SearchLast = 8'(PRE_CHK - 1);
   localparam logic [7:0] DecLast    = 8'(MSG_LEN - 1);
   localparam logic [3:0] LastPtrn   = 4'(NumPtrn - 1);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;           // LOAD cycle, SEARCH step k, or DECRYPT byte n
   logic [3:0] pidx_q, pidx_d;         // pattern under test in SEARCH
   logic       wr_phase_q, wr_phase_d; // DECRYPT: 0 = read cycle, 1 = write cycle
   logic [6:0] buf_q [PRE_CHK];
   logic [6:0] buf_d [PRE_CHK];
   logic [3:0] ptrn_idx_q, ptrn_idx_d;
   logic       ptrn_err_q, ptrn_err_d;
   logic [6:0] par_q, par_d;

   logic       lfsr_load, lfsr_step;
   logic [6:0] lfsr_load_val, lfsr_taps, lfsr_q, lfsr_next;
   logic [6:0] buf_k;

   lfsr7 u_lfsr (
      .clk_i      (Clk),
      .rst_i      (Reset),
      .load_i     (lfsr_load),
      .load_val_i (lfsr_load_val),
      .step_i     (lfsr_step),
      .taps_i     (lfsr_taps),
      .q_o        (lfsr_q),
      .next_o     (lfsr_next)
   );

   // Expected LFSR output for the current SEARCH step.
   always_comb begin
      buf_k = '0;
      for (int i = 0; i < PRE_CHK; i++) begin
         if (cnt_q == 8'(i)) buf_k = buf_q[i];
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pidx_d        = pidx_q;
      wr_phase_d    = wr_phase_q;
      buf_d         = buf_q;
      ptrn_idx_d    = ptrn_idx_q;
      ptrn_err_d    = ptrn_err_q;
      par_d         = par_q;
      lfsr_load     = 1'b0;
      lfsr_load_val = buf_q[0];
      lfsr_step     = 1'b0;
      lfsr_taps     = ptrn_taps(ptrn_idx_q);
      // Address/data are zero whenever the memory is not in use, so reset
      // (which returns to IDLE) also clears them.
      mem_addr      = '0;
      mem_we        = 1'b0;
      mem_wdata     = '0;
      Ack           = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (!Start) begin
               state_d    = StLoad;
               cnt_d      = '0;
               ptrn_idx_d = '0;
               ptrn_err_d = 1'b0;
               par_d      = '0;
            end
         end

         StLoad: begin
            // Address issued on cycle c, data captured on cycle c+1.
            if (cnt_q != LoadLast) mem_addr = CryptoBase + cnt_q;
            for (int i = 0; i < PRE_CHK; i++) begin
               if (cnt_q == 8'(i + 1)) buf_d[i] = mem_rdata[6:0];
            end
            if (cnt_q == LoadLast) begin
               cnt_d  = 8'd1;
               pidx_d = '0;
               if (buf_q[0] == '0) begin
                  ptrn_err_d = 1'b1;
                  state_d    = StDone;
               end else begin
                  state_d   = StSearch;
                  lfsr_load = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         StSearch: begin
            lfsr_taps = ptrn_taps(pidx_q);
            if (lfsr_next == buf_k) begin
               if (cnt_q == SearchLast) begin
                  ptrn_idx_d = pidx_q;
                  state_d    = StDecrypt;
                  cnt_d      = '0;
                  wr_phase_d = 1'b0;
                  lfsr_load  = 1'b1;
               end else begin
                  lfsr_step = 1'b1;
                  cnt_d     = cnt_q + 8'd1;
               end
            end else if (pidx_q == LastPtrn) begin
               ptrn_err_d = 1'b1;
               state_d    = StDone;
            end else begin
               pidx_d    = pidx_q + 4'd1;
               cnt_d     = 8'd1;
               lfsr_load = 1'b1;
            end
         end

         StDecrypt: begin
            if (!wr_phase_q) begin
               mem_addr   = CryptoBase + cnt_q;
               wr_phase_d = 1'b1;
            end else begin
               mem_addr   = PlainBase + cnt_q;
               mem_we     = 1'b1;
               mem_wdata  = {1'b0, mem_rdata[6:0] ^ lfsr_q} + 8'h20;
               lfsr_step  = 1'b1;
               wr_phase_d = 1'b0;
               if ((mem_rdata[7] != ^mem_rdata[6:0]) && (par_q != 7'h7F)) begin
                  par_d = par_q + 7'd1;
               end
               if (cnt_q == DecLast) begin
                  state_d = StDone;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end

         StDone: begin
            Ack = 1'b1;
            if (Start) state_d = StIdle;
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         pidx_q     <= '0;
         wr_phase_q <= 1'b0;
         ptrn_idx_q <= '0;
         ptrn_err_q <= 1'b0;
         par_q      <= '0;
         for (int i = 0; i < PRE_CHK; i++) buf_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pidx_q     <= pidx_d;
         wr_phase_q <= wr_phase_d;
         ptrn_idx_q <= ptrn_idx_d;
         ptrn_err_q <= ptrn_err_d;
         par_q      <= par_d;
         buf_q      <= buf_d;
      end
   end

   assign ptrn_idx    = ptrn_idx_q;
   assign ptrn_err    = ptrn_err_q;
   assign par_err_cnt = par_q;

endmodule

// File: tb/tb_decrypt_ctrl.sv
// Bench for decrypt_ctrl: table-driven directed runs, reset corner cases and
// randomized messages checked against a behavioural model of the cipher.
module tb_decrypt_ctrl;

   localparam int PreChk = 10;
   localparam int MsgLen = 64;
   localparam int CBase  = 64;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       Start = 1'b1;
   logic       Ack;
   logic [7:0] mem_addr;
   logic       mem_we;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata = 8'h00;
   logic [3:0] ptrn_idx;
   logic       ptrn_err;
   logic [6:0] par_err_cnt;

   always #5 Clk = ~Clk;

   decrypt_ctrl #(
      .CRYPTO_BASE (CBase),
      .PLAIN_BASE  (0),
      .MSG_LEN     (MsgLen),
      .PRE_CHK     (PreChk)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .Start       (Start),
      .Ack         (Ack),
      .mem_addr    (mem_addr),
      .mem_we      (mem_we),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .ptrn_idx    (ptrn_idx),
      .ptrn_err    (ptrn_err),
      .par_err_cnt (par_err_cnt)
   );

   // Memory: reads come from the image the bench builds, writes land in wmem.
   logic [7:0] img  [256];
   logic [7:0] wmem [256];
   logic       clr_wmem = 1'b0;
   int         wr_cnt = 0;

   always @(posedge Clk) begin
      mem_rdata <= img[mem_addr];
      if (clr_wmem) begin
         for (int i = 0; i < 256; i++) wmem[i] <= 8'hEE;
         wr_cnt <= 0;
      end else if (mem_we) begin
         wmem[mem_addr] <= mem_wdata;
         wr_cnt <= wr_cnt + 1;
      end
   end

   int n_cmp = 0;
   int n_fail = 0;

   logic [6:0] taps_tab [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};
   logic [7:0] plain     [MsgLen];
   logic [7:0] exp_plain [MsgLen];
   int         exp_idx, exp_err, exp_par, exp_cyc;

   typedef struct {
      string name;
      int    ptrn;
      int    init;
      int    kind;   // 0 Watson, 1 spaces, 2 zero first byte, 3 garbage
      int    flip;   // crypto address whose bit 7 is flipped, -1 for none
      int    e_idx;
      int    e_err;
      int    e_par;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   function automatic logic [6:0] lstep(input logic [6:0] l, input logic [6:0] t);
      return {l[5:0], ^(l & t)};
   endfunction

   task automatic build_image(input int p, input logic [6:0] init, input int kind);
      string      w = "Mr. Watson, come here. I want to see you.";
      logic [6:0] l;
      logic [6:0] c;
      logic [7:0] d;
      for (int n = 0; n < MsgLen; n++) plain[n] = 8'h20;
      if (kind == 0 || kind == 2) begin
         for (int i = 0; i < w.len(); i++) plain[PreChk + i] = w[i];
      end
      if (kind == 4) begin
         for (int n = PreChk; n < MsgLen; n++) plain[n] = 8'($urandom_range(32, 126));
      end
      for (int i = 0; i < 256; i++) img[i] = 8'h00;
      l = init;
      for (int n = 0; n < MsgLen; n++) begin
         d = plain[n] - 8'h20;
         c = d[6:0] ^ l;
         img[CBase + n] = {^c, c};
         l = lstep(l, taps_tab[p]);
      end
      if (kind == 2) img[CBase] = 8'h00;
      if (kind == 3) begin
         for (int n = 0; n < MsgLen; n++) img[CBase + n] = 8'h7F;
         img[CBase] = 8'h01;
      end
   endtask

   // Reference: try each tap pattern on the known-space prefix, then decrypt.
   task automatic model_run();
      logic [6:0] b [PreChk];
      logic [6:0] l;
      logic [7:0] d;
      int         s;
      bit         ok;
      for (int k = 0; k < PreChk; k++) b[k] = img[CBase + k][6:0];
      exp_idx = 0;
      exp_err = 0;
      exp_par = 0;
      for (int n = 0; n < MsgLen; n++) exp_plain[n] = 8'hEE;
      if (b[0] == 7'h00) begin
         exp_err = 1;
         exp_cyc = PreChk + 2;
         return;
      end
      s = 0;
      exp_err = 1;
      for (int p = 0; p < 9 && exp_err == 1; p++) begin
         l  = b[0];
         ok = 1'b1;
         for (int k = 1; k < PreChk && ok; k++) begin
            l = lstep(l, taps_tab[p]);
            s++;
            if (l != b[k]) ok = 1'b0;
         end
         if (ok) begin
            exp_err = 0;
            exp_idx = p;
         end
      end
      if (exp_err == 1) begin
         exp_cyc = PreChk + 2 + s;
         return;
      end
      l = b[0];
      for (int n = 0; n < MsgLen; n++) begin
         d = img[CBase + n];
         exp_plain[n] = {1'b0, d[6:0] ^ l} + 8'h20;
         if (d[7] != ^d[6:0] && exp_par < 127) exp_par++;
         l = lstep(l, taps_tab[exp_idx]);
      end
      exp_cyc = PreChk + 2 + s + 2 * MsgLen;
   endtask

   task automatic do_run(input string tag, output int g_idx, output int g_err, output int g_par);
      int cyc;
      int stray;
      model_run();
      clr_wmem = 1'b1;
      tick();
      clr_wmem = 1'b0;
      Start = 1'b0;
      cyc = 0;
      while (!Ack && cyc < 1000) begin
         tick();
         cyc++;
      end
      check({tag, " latency"}, cyc, exp_cyc);
      check({tag, " ptrn_idx"}, int'(ptrn_idx), exp_idx);
      check({tag, " ptrn_err"}, int'(ptrn_err), exp_err);
      check({tag, " par_err_cnt"}, int'(par_err_cnt), exp_par);
      for (int n = 0; n < MsgLen; n++) begin
         check($sformatf("%s mem[%0d]", tag, n), int'(wmem[n]), int'(exp_plain[n]));
      end
      stray = 0;
      for (int i = MsgLen; i < 256; i++) if (wmem[i] != 8'hEE) stray++;
      check({tag, " stray writes"}, stray, 0);
      g_idx = int'(ptrn_idx);
      g_err = int'(ptrn_err);
      g_par = int'(par_err_cnt);
      // DONE ignores Start low and keeps its results.
      repeat (3) tick();
      check({tag, " Ack held"}, int'(Ack), 1);
      check({tag, " ptrn_idx held"}, int'(ptrn_idx), exp_idx);
      check({tag, " par held"}, int'(par_err_cnt), exp_par);
      Start = 1'b1;
      tick();
      check({tag, " Ack drop"}, int'(Ack), 0);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " Ack"}, int'(Ack), 0);
      check({tag, " mem_we"}, int'(mem_we), 0);
      check({tag, " mem_addr"}, int'(mem_addr), 0);
      check({tag, " mem_wdata"}, int'(mem_wdata), 0);
      check({tag, " ptrn_idx"}, int'(ptrn_idx), 0);
      check({tag, " ptrn_err"}, int'(ptrn_err), 0);
      check({tag, " par_err_cnt"}, int'(par_err_cnt), 0);
   endtask

   vec_t vecs [6];

   initial begin
      int gi, ge, gp, cyc, nf;

      vecs[0] = '{"watson",  3, 'h01, 0, -1, 3, 0, 0};
      vecs[1] = '{"spaces",  0, 'h7F, 1, -1, 0, 0, 0};
      vecs[2] = '{"parflip", 3, 'h01, 0, 70, 3, 0, 1};
      vecs[3] = '{"zero0",   3, 'h01, 2, -1, 0, 1, 0};
      vecs[4] = '{"nomatch", 0, 'h01, 3, -1, 0, 1, 0};
      vecs[5] = '{"again",   3, 'h01, 0, -1, 3, 0, 0};

      for (int i = 0; i < 256; i++) img[i] = 8'h00;

      // Reset wins over Start low: the block must not start loading.
      Reset = 1'b1;
      Start = 1'b0;
      repeat (3) begin
         tick();
         check("rst prio mem_addr", int'(mem_addr), 0);
      end
      check_idle_outputs("reset");

      // Start held high after reset: nothing happens.
      Start = 1'b1;
      tick();
      Reset = 1'b0;
      repeat (200) begin
         tick();
         check("hold mem_we", int'(mem_we), 0);
         check("hold Ack", int'(Ack), 0);
      end

      foreach (vecs[v]) begin
         build_image(vecs[v].ptrn, 7'(vecs[v].init), vecs[v].kind);
         if (vecs[v].flip >= 0) img[vecs[v].flip][7] = ~img[vecs[v].flip][7];
         do_run(vecs[v].name, gi, ge, gp);
         check({vecs[v].name, " tab idx"}, gi, vecs[v].e_idx);
         check({vecs[v].name, " tab err"}, ge, vecs[v].e_err);
         check({vecs[v].name, " tab par"}, gp, vecs[v].e_par);
      end

      // Reset in the middle of DECRYPT, on the write cycle of byte 20.
      build_image(3, 7'h01, 0);
      model_run();
      clr_wmem = 1'b1;
      tick();
      clr_wmem = 1'b0;
      Start = 1'b0;
      cyc = 0;
      while (!(mem_we && mem_addr == 8'd20) && cyc < 1000) begin
         tick();
         cyc++;
      end
      check("midrst reached byte 20", int'(mem_we && mem_addr == 8'd20), 1);
      Reset = 1'b1;
      Start = 1'b1;
      tick();
      Reset = 1'b0;
      check_idle_outputs("midrst");
      repeat (20) begin
         tick();
         check("midrst idle mem_we", int'(mem_we), 0);
         check("midrst idle Ack", int'(Ack), 0);
      end
      check("midrst write count", wr_cnt, 21);
      for (int n = 0; n < MsgLen; n++) begin
         check($sformatf("midrst mem[%0d]", n), int'(wmem[n]),
               n <= 20 ? int'(exp_plain[n]) : 32'hEE);
      end
      do_run("rerun", gi, ge, gp);
      check("rerun tab idx", gi, 3);

      // Randomized messages, patterns, seeds and parity faults.
      for (int r = 0; r < 10; r++) begin
         build_image($urandom_range(0, 8), 7'($urandom_range(0, 127)), 4);
         nf = $urandom_range(0, 3);
         for (int f = 0; f < nf; f++) begin
            gi = CBase + $urandom_range(0, MsgLen - 1);
            img[gi][7] = ~img[gi][7];
         end
         do_run($sformatf("rand%0d", r), gi, ge, gp);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
